calc_sequencer: RTL and testbench

Key-entry sequencer for the four-function calculator datapath. It turns single-cycle key events into signed `operand1`, `operand2` and a 3-bit `operator` code, and issues one compute strobe per `=`. It then waits a fixed number of cycles, captures the datapath's `ans` and drives the value to be displayed. It sits between the keypad decoder and the arithmetic datapath, and its `display` output feeds the 7-segment formatter.

---
 rtl/calc_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Key-entry sequencer for the four-function calculator: builds signed operands
// and an operator from key events, strobes the datapath and captures its answer.
module calc_sequencer #(
  parameter int unsigned MAX_DIGITS  = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        sw_clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  input  logic [31:0] ans,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic [2:0]  operator,
  output logic        calc_go,
  output logic [31:0] display,
  output logic        busy,
  output logic        error
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 2);
  localparam int unsigned WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [31:0] ERR_CODE = 32'h00EE_0000;
  localparam logic [31:0] POS_MAX  = 32'd999999;
  localparam logic [31:0] NEG_MAX  = 32'd99999;

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_OP_SEL,
    S_ENTER_B,
    S_EXEC,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  state_t          state, state_n;
  logic [31:0]     op1_n, op2_n, disp_n;
  logic [2:0]      opr_n;
  logic [31:0]     mag, mag_n;
  logic            neg, neg_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [WW-1:0]   wcnt, wcnt_n;

  logic            is_digit, is_op, is_eq, is_clr, is_neg;
  logic [31:0]     d;
  logic [2:0]      key_opr;
  logic [31:0]     dig_mag, dig_val, neg_val;
  logic [CW-1:0]   dig_cnt, fresh_cnt;
  logic            dig_ok, neg_ok;

  assign is_digit = key_valid && (key_code <= 5'd9);
  assign is_op    = key_valid && (key_code >= 5'd10) && (key_code <= 5'd14);
  assign is_eq    = key_valid && (key_code == 5'd15);
  assign is_clr   = key_valid && (key_code == 5'd16);
  assign is_neg   = key_valid && (key_code == 5'd17);
  assign d        = {27'b0, key_code};
  assign key_opr  = 3'(key_code - 5'd9);

  // The entry works on a magnitude plus sign so that -0 keeps its sign for
  // subsequent digits; the digit count stays 0 while only zeros are entered.
  assign dig_mag   = mag * 32'd10 + d;
  assign dig_cnt   = (dig_mag == '0) ? '0 : cnt + CW'(1);
  assign dig_ok    = (dig_cnt <= CW'(MAX_DIGITS)) &&
                     (dig_mag <= (neg ? NEG_MAX : POS_MAX));
  assign dig_val   = neg ? -dig_mag : dig_mag;
  assign neg_ok    = neg || (mag <= NEG_MAX);
  assign neg_val   = neg ? mag : -mag;
  assign fresh_cnt = (key_code == 5'd0) ? '0 : CW'(1);

  always_comb begin
    state_n = state;
    op1_n   = operand1;
    op2_n   = operand2;
    opr_n   = operator;
    disp_n  = display;
    mag_n   = mag;
    neg_n   = neg;
    cnt_n   = cnt;
    wcnt_n  = wcnt;

    if (is_clr) begin
      state_n = S_ENTER_A;
      op1_n   = '0;
      op2_n   = '0;
      opr_n   = '0;
      disp_n  = '0;
      mag_n   = '0;
      neg_n   = 1'b0;
      cnt_n   = '0;
      wcnt_n  = '0;
    end else begin
      case (state)
        S_ENTER_A: begin
          if (is_digit && dig_ok) begin
            mag_n  = dig_mag;
            cnt_n  = dig_cnt;
            op1_n  = dig_val;
            disp_n = dig_val;
          end else if (is_neg && neg_ok) begin
            neg_n  = ~neg;
            op1_n  = neg_val;
            disp_n = neg_val;
          end else if (is_op) begin
            opr_n   = key_opr;
            disp_n  = operand1;
            state_n = S_OP_SEL;
          end
        end

        S_OP_SEL: begin
          if (is_op) begin
            opr_n = key_opr;
          end else if (is_digit) begin
            op2_n   = d;
            disp_n  = d;
            mag_n   = d;
            neg_n   = 1'b0;
            cnt_n   = fresh_cnt;
            state_n = S_ENTER_B;
          end
        end

        S_ENTER_B: begin
          if (is_digit && dig_ok) begin
            mag_n  = dig_mag;
            cnt_n  = dig_cnt;
            op2_n  = dig_val;
            disp_n = dig_val;
          end else if (is_neg && neg_ok) begin
            neg_n  = ~neg;
            op2_n  = neg_val;
            disp_n = neg_val;
          end else if (is_eq) begin
            wcnt_n  = '0;
            state_n = S_EXEC;
          end
        end

        // EXEC plus WAIT together last WAIT_CYCLES cycles; capture on the last.
        S_EXEC, S_WAIT: begin
          if (wcnt == WW'(WAIT_CYCLES - 1)) begin
            disp_n  = ans;
            wcnt_n  = '0;
            state_n = (ans == ERR_CODE) ? S_ERR : S_SHOW;
          end else begin
            wcnt_n  = wcnt + WW'(1);
            state_n = S_WAIT;
          end
        end

        S_SHOW, S_ERR: begin
          if (is_digit) begin
            op1_n   = d;
            op2_n   = '0;
            opr_n   = '0;
            disp_n  = d;
            mag_n   = d;
            neg_n   = 1'b0;
            cnt_n   = fresh_cnt;
            state_n = S_ENTER_A;
          end else if (is_op && (state == S_SHOW)) begin
            op1_n   = display;
            op2_n   = '0;
            opr_n   = key_opr;
            state_n = S_OP_SEL;
          end
        end

        default: state_n = S_ENTER_A;
      endcase
    end
  end

  always_ff @(posedge sw_clk) begin
    if (rst) begin
      state    <= S_ENTER_A;
      operand1 <= '0;
      operand2 <= '0;
      operator <= '0;
      display  <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      wcnt     <= '0;
    end else begin
      state    <= state_n;
      operand1 <= op1_n;
      operand2 <= op2_n;
      operator <= opr_n;
      display  <= disp_n;
      mag      <= mag_n;
      neg      <= neg_n;
      cnt      <= cnt_n;
      wcnt     <= wcnt_n;
    end
  end

  assign calc_go = (state == S_EXEC);
  assign busy    = (state == S_EXEC) || (state == S_WAIT);
  assign error   = (state == S_ERR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed key sequences followed by
// random key traffic, compared each cycle against a behavioural calculator model.
module tb_calc_sequencer;

  localparam int MAXD  = 6;
  localparam int WAITC = 2;
  localparam int ERRV  = 32'h00EE0000;

  logic        sw_clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic [31:0] ans = '0;
  logic [31:0] operand1, operand2, display;
  logic [2:0]  operator;
  logic        calc_go, busy, error;

  calc_sequencer #(.MAX_DIGITS(MAXD), .WAIT_CYCLES(WAITC)) dut (
    .sw_clk(sw_clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .ans(ans), .operand1(operand1), .operand2(operand2), .operator(operator),
    .calc_go(calc_go), .display(display), .busy(busy), .error(error)
  );

  always #5 sw_clk = ~sw_clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 first operand, 1 operator chosen, 2 second operand,
  // 3 result shown, 4 error shown; m_left > 0 means a computation is in flight.
  int m_op1, m_op2, m_opr, m_disp, m_left, m_mode;
  bit m_go, m_neg;

  function automatic int ndig(int v);
    int n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic void m_reset();
    m_op1 = 0; m_op2 = 0; m_opr = 0; m_disp = 0;
    m_left = 0; m_mode = 0; m_go = 0; m_neg = 0;
  endfunction

  function automatic int add_digit(int v, int dg);
    int mag, nm, nv;
    mag = m_neg ? -v : v;
    nm  = mag * 10 + dg;
    nv  = m_neg ? -nm : nm;
    if (ndig(nm) <= MAXD && nv >= -99999 && nv <= 999999) begin
      m_disp = nv;
      return nv;
    end
    return v;
  endfunction

  function automatic int flip(int v);
    if (-v >= -99999) begin
      m_neg  = !m_neg;
      m_disp = -v;
      return -v;
    end
    return v;
  endfunction

  function automatic void m_step(bit kv, int code, bit rs, int a);
    bit dig, op;
    m_go = 0;
    if (rs || (kv && code == 16)) begin
      m_reset();
      return;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_disp = a;
        m_mode = (a == ERRV) ? 4 : 3;
      end
      return;
    end
    if (!kv) return;
    dig = (code <= 9);
    op  = (code >= 10 && code <= 14);
    case (m_mode)
      0: begin
        if (dig) m_op1 = add_digit(m_op1, code);
        else if (code == 17) m_op1 = flip(m_op1);
        else if (op) begin m_opr = code - 9; m_mode = 1; m_disp = m_op1; end
      end
      1: begin
        if (op) m_opr = code - 9;
        else if (dig) begin m_op2 = code; m_neg = 0; m_disp = code; m_mode = 2; end
      end
      2: begin
        if (dig) m_op2 = add_digit(m_op2, code);
        else if (code == 17) m_op2 = flip(m_op2);
        else if (code == 15) begin m_go = 1; m_left = WAITC; m_mode = 3; end
      end
      default: begin
        if (dig) begin
          m_op1 = code; m_op2 = 0; m_opr = 0; m_neg = 0; m_disp = code; m_mode = 0;
        end else if (op && m_mode == 3) begin
          m_op1 = m_disp; m_op2 = 0; m_opr = code - 9; m_mode = 1;
        end
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_all();
    chk("operand1", operand1, m_op1);
    chk("operand2", operand2, m_op2);
    chk("operator", {29'b0, operator}, m_opr);
    chk("calc_go", {31'b0, calc_go}, {31'b0, m_go});
    chk("display", display, m_disp);
    chk("busy", {31'b0, busy}, (m_left > 0) ? 1 : 0);
    chk("error", {31'b0, error}, (m_mode == 4 && m_left == 0) ? 1 : 0);
  endtask

  task automatic step(input bit kv, input int code, input bit rs);
    key_valid = kv;
    key_code  = code[4:0];
    rst       = rs;
    m_step(kv, code, rs, ans);
    @(posedge sw_clk);
    #1;
    key_valid = 1'b0;
    rst       = 1'b0;
    check_all();
  endtask

  task automatic key(input int code);
    step(1'b1, code, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  int r, code;
  bit kv, rs;

  initial begin
    m_reset();
    step(1'b0, 0, 1'b1);
    chk("reset_display", display, 0);

    // 12 * 34 = 408
    ans = 408;
    key(1); key(2); key(10); key(3); key(4); key(15);
    chk("tp1_go", {31'b0, calc_go}, 1);
    chk("tp1_op1", operand1, 12);
    chk("tp1_op2", operand2, 34);
    idle(1);
    chk("tp1_go_once", {31'b0, calc_go}, 0);
    chk("tp1_busy2", {31'b0, busy}, 1);
    idle(1);
    chk("tp1_display", display, 408);
    chk("tp1_busy_drop", {31'b0, busy}, 0);

    // chaining: 408 + 2
    key(12); key(2);
    ans = $urandom_range(0, 5000);
    key(15);
    chk("chain_op1", operand1, 408);
    chk("chain_op2", operand2, 2);
    chk("chain_opr", {29'b0, operator}, 3);
    idle(3);

    // divide-by-zero sentinel
    key(16);
    ans = ERRV;
    key(7); key(11); key(0); key(15); idle(2);
    chk("err_flag", {31'b0, error}, 1);
    key(12);
    chk("err_ignore_op", {31'b0, error}, 1);
    key(5);
    chk("err_recover", operand1, 5);

    // digit limit and out-of-range negate
    key(16);
    for (int k = 1; k <= 7; k++) key(k);
    chk("max_digits", operand1, 123456);
    key(17);
    chk("neg_range", operand1, 123456);

    // clear during WAIT discards the pending answer
    key(16);
    ans = 6;
    key(9); key(13); key(3); key(15); idle(1);
    key(16);
    idle(3);
    chk("clr_wait_display", display, 0);

    // negate then operator replacement
    key(5); key(17); key(14); key(12); key(2);
    ans = $urandom_range(0, 100);
    key(15);
    chk("neg_op1", operand1, -5);
    chk("replace_opr", {29'b0, operator}, 3);
    idle(2);
    step(1'b1, 3, 1'b1);
    chk("rst_over_key", operand1, 0);

    // random key traffic
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 99) < 2);
      kv = ($urandom_range(0, 2) != 0);
      r  = $urandom_range(0, 99);
      if (r < 50)      code = $urandom_range(0, 9);
      else if (r < 68) code = $urandom_range(10, 14);
      else if (r < 80) code = 15;
      else if (r < 84) code = 16;
      else if (r < 93) code = 17;
      else             code = $urandom_range(18, 31);
      ans = ($urandom_range(0, 5) == 0) ? ERRV : $urandom_range(0, 2000) - 1000;
      step(kv, code, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
